// File: rtl/branch_predict_unit.sv
// Branch predict unit: resolves conditional branches from ALU flags and
// funct3 at execute, and predicts them at fetch from a PC-indexed table of
// 2-bit saturating counters. Trains on every legal resolved branch, reports
// mispredicts/illegal encodings one cycle later and keeps saturating stats.
module branch_predict_unit #(
  parameter int          PC_W       = 32,
  parameter int          IDX_W      = 6,
  parameter int          CNT_W      = 16,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  parameter bit          PREDICT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             pred_taken,
  input  logic             Branch,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [2:0]       funct3,
  input  logic [3:0]       flags,
  input  logic             ex_pred_taken,
  output logic             taken,
  output logic             mispredict,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int DEPTH = 2 ** IDX_W;

  // Move a 2-bit counter one step toward taken or not-taken, clamping at 11/00.
  function automatic logic [1:0] sat_ctr2(input logic [1:0] ctr, input logic up);
    logic [1:0] res;
    res = ctr;
    if (up) begin
      if (ctr != 2'b11) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'd1;
    end
    return res;
  endfunction

  // Increment a statistics counter, holding at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&cnt) ? cnt : cnt + one;
  endfunction

  logic [1:0]       bht_q [DEPTH];
  logic [1:0]       bht_d [DEPTH];
  logic             mispredict_q, mispredict_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             z_flag, n_flag, c_flag, v_flag;
  logic             cond_true;
  logic             legal_f3;
  logic             legal_evt;
  logic             wrong_pred;

  // Word-aligned PCs: drop the byte offset, keep IDX_W bits above it.
  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign upd_idx   = ex_pc[IDX_W+1:2];

  // PC bits outside the index field do not take part in table lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  assign {z_flag, n_flag, c_flag, v_flag} = flags;

  // Evaluate the branch condition selected by funct3; 2 and 3 are unused encodings.
  always_comb begin
    cond_true = 1'b0;
    legal_f3  = 1'b1;
    case (funct3)
      3'd0:    cond_true = z_flag;
      3'd1:    cond_true = ~z_flag;
      3'd4:    cond_true = n_flag ^ v_flag;
      3'd5:    cond_true = ~(n_flag ^ v_flag);
      3'd6:    cond_true = ~c_flag;
      3'd7:    cond_true = c_flag;
      default: legal_f3  = 1'b0;
    endcase
  end

  assign taken      = Branch & legal_f3 & cond_true;
  assign legal_evt  = Branch & legal_f3;
  assign wrong_pred = legal_evt & (taken != ex_pred_taken);

  // Lookup reads the registered table, so a same-cycle update shows next cycle.
  assign pred_taken = PREDICT_EN & bht_q[fetch_idx][1];

  // Next table contents: train the resolved entry on each legal branch.
  always_comb begin
    bht_d = bht_q;
    if (PREDICT_EN && legal_evt) begin
      bht_d[upd_idx] = sat_ctr2(bht_q[upd_idx], taken);
    end
  end

  // Next status flags and statistics for the branch in execute this cycle.
  always_comb begin
    mispredict_d  = wrong_pred;
    illegal_d     = Branch & ~legal_f3;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (legal_evt) begin
      branch_cnt_d = sat_inc(branch_cnt_q);
      if (wrong_pred) mispred_cnt_d = sat_inc(mispred_cnt_q);
    end
  end

  // Counter table in flops so reset restores every entry in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= INIT_STATE;
    end else begin
      bht_q <= bht_d;
    end
  end

  // Registered pulses and statistics; reset discards any branch in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q  <= mispredict_d;
      illegal_q     <= illegal_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispredict       = mispredict_q;
  assign illegal_branch   = illegal_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule
